// File: rtl/core_pkg.sv
// Shared definitions for the pipelined ARM core front end.
//   RESET_PC_DEF  : default PC after reset
//   NOP_INSTR_DEF : default bubble instruction placed in the IF/ID register
//   PC_INC        : sequential fetch increment (one 32-bit instruction)
//   npc_sel_e     : next-PC source select (sequential / write-back / branch)
package core_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_W   = 2'd1,
        NPC_BR  = 2'd2
    } npc_sel_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: width-parameterised pipeline flop.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, loads CLR_VAL
//   clear : synchronous clear to CLR_VAL, takes priority over en
//   en    : load d when high, hold otherwise
//   d     : next value
//   q     : registered value
module ifid_reg #(
    parameter int unsigned     W       = 32,
    parameter logic [W-1:0]    CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= CLR_VAL;
        end else if (clear) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   StallF        : hold the PC
//   StallD        : hold the IF/ID register
//   FlushD        : clear the IF/ID register to a bubble (wins over StallD)
//   BranchTakenE  : redirect to ALUResultE (highest priority)
//   PCSrcW        : redirect to ResultW
//   InstrF        : instruction memory data for PCF (combinational imem)
//   PCF, PCPlus4F : fetch address and its sequential successor
//   InstrD        : registered instruction for decode
//   PCPlus8D      : registered PC+8 of the instruction in D (R15 read value)
//   ValidD        : InstrD holds a real fetched instruction
//   RedirectCnt   : saturating count of cycles FlushD was applied
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [31:0]      ALUResultE,
    input  logic             PCSrcW,
    input  logic [31:0]      ResultW,
    input  logic [31:0]      InstrF,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus8D,
    output logic             ValidD,
    output logic [CNT_W-1:0] RedirectCnt
);

    npc_sel_e    npc_sel;
    logic [31:0] pc_next;

    assign PCPlus4F = PCF + PC_INC;

    always_comb begin
        npc_sel = NPC_SEQ;
        if (BranchTakenE) begin
            npc_sel = NPC_BR;
        end else if (PCSrcW) begin
            npc_sel = NPC_W;
        end
    end

    always_comb begin
        pc_next = PCPlus4F;
        unique case (npc_sel)
            NPC_BR:  pc_next = ALUResultE;
            NPC_W:   pc_next = ResultW;
            default: pc_next = PCPlus4F;
        endcase
    end

    // A stalled F drops any redirect presented in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= pc_next;
        end
    end

    ifid_reg #(.W(32), .CLR_VAL(NOP_INSTR)) u_instr (
        .clk   (clk),
        .reset (reset),
        .clear (FlushD),
        .en    (!StallD),
        .d     (InstrF),
        .q     (InstrD)
    );

    ifid_reg #(.W(32), .CLR_VAL(32'h0000_0000)) u_pc8 (
        .clk   (clk),
        .reset (reset),
        .clear (FlushD),
        .en    (!StallD),
        .d     (PCPlus4F + PC_INC),
        .q     (PCPlus8D)
    );

    ifid_reg #(.W(1), .CLR_VAL(1'b0)) u_valid (
        .clk   (clk),
        .reset (reset),
        .clear (FlushD),
        .en    (!StallD),
        .d     (1'b1),
        .q     (ValidD)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RedirectCnt <= '0;
        end else if (FlushD && (RedirectCnt != '1)) begin
            RedirectCnt <= RedirectCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (counter width reduced to 4 to reach saturation).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        BranchTakenE = 1'b0, PCSrcW = 1'b0;
    logic [31:0] ALUResultE = '0, ResultW = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF, PCPlus4F, InstrD, PCPlus8D;
    logic        ValidD;
    logic [3:0]  RedirectCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .InstrF       (InstrF),
        .PCF          (PCF),
        .PCPlus4F     (PCPlus4F),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD),
        .RedirectCnt  (RedirectCnt)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    assign InstrF = rom(PCF);

    // Hazard-unit contract: F is never stalled while a redirect is presented.
    always @(posedge clk) begin
        if (!reset && (StallF || BranchTakenE || PCSrcW)) begin
            checks++;
            assert (!(StallF && (BranchTakenE || PCSrcW))) else begin
                errors++;
                $error("FAIL stall_vs_redirect: StallF=%0b BranchTakenE=%0b PCSrcW=%0b required no overlap",
                       StallF, BranchTakenE, PCSrcW);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p8, input logic v);
        chk({tag, "_pcf"}, PCF, pc);
        chk({tag, "_instrd"}, InstrD, ins);
        chk({tag, "_pc8d"}, PCPlus8D, p8);
        chk({tag, "_validd"}, {31'd0, ValidD}, {31'd0, v});
    endtask

    initial begin
        #3;
        chk_d("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst_cnt", {28'd0, RedirectCnt}, 32'd0);
        chk("rst_pc4", PCPlus4F, 32'h4);
        #9 reset = 1'b0;
        #1 chk("rel_pcf", PCF, 32'h0);

        // Sequential fetch.
        step(); chk_d("seq1", 32'h4, rom(32'h0), 32'h8,  1'b1);
        step(); chk_d("seq2", 32'h8, rom(32'h4), 32'hC,  1'b1);
        step(); chk_d("seq3", 32'hC, rom(32'h8), 32'h10, 1'b1);
        step(); chk_d("seq4", 32'h10, rom(32'hC), 32'h14, 1'b1);

        // Stall F and D for three cycles.
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_d("stall", 32'h10, rom(32'hC), 32'h14, 1'b1);
        end
        StallF = 1'b0; StallD = 1'b0;
        step(); chk_d("unstall", 32'h14, rom(32'h10), 32'h18, 1'b1);

        // Branch with flush.
        BranchTakenE = 1'b1; ALUResultE = 32'h100; FlushD = 1'b1;
        step(); chk_d("br", 32'h100, 32'h0, 32'h0, 1'b0);
        chk("br_cnt", {28'd0, RedirectCnt}, 32'd1);
        BranchTakenE = 1'b0; FlushD = 1'b0;
        step(); chk_d("br_next", 32'h104, rom(32'h100), 32'h108, 1'b1);

        // Branch beats W redirect.
        BranchTakenE = 1'b1; ALUResultE = 32'h200; PCSrcW = 1'b1; ResultW = 32'h300;
        step(); chk_d("prio", 32'h200, rom(32'h104), 32'h10C, 1'b1);
        BranchTakenE = 1'b0;
        step(); chk_d("wonly", 32'h300, rom(32'h200), 32'h208, 1'b1);
        PCSrcW = 1'b0;

        // Flush wins over StallD.
        FlushD = 1'b1; StallD = 1'b1;
        step(); chk_d("flstall", 32'h304, 32'h0, 32'h0, 1'b0);
        chk("flstall_cnt", {28'd0, RedirectCnt}, 32'd2);
        FlushD = 1'b0; StallD = 1'b0;

        // 32-bit wrap of PC+4 and PC+8.
        PCSrcW = 1'b1; ResultW = 32'hFFFF_FFFC;
        step(); chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4F, 32'h0);
        PCSrcW = 1'b0;
        step(); chk_d("wrap_d", 32'h0, 32'hFFFF_FFFC, 32'h4, 1'b1);

        // Counter saturation with a 4-bit counter.
        FlushD = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat_cnt", {28'd0, RedirectCnt}, (2 + i > 15) ? 32'd15 : 32'(2 + i));
        end
        FlushD = 1'b0;

        // Asynchronous reset in the middle of a stall.
        StallF = 1'b1; StallD = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        chk_d("areset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("areset_cnt", {28'd0, RedirectCnt}, 32'd0);
        chk("areset_pc4", PCPlus4F, 32'h4);
        StallF = 1'b0; StallD = 1'b0;
        step();
        reset = 1'b0;
        step(); chk_d("after_rst", 32'h4, rom(32'h0), 32'h8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
